multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

- Sequencing controller for the multi-cycle RISC-V datapath.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Decodes opcode/funct fields into the ALU's 5-bit function code (the `ALU_*` codes from `Definition_List.v`).
- Drives the PC, IR, memory and register-file enables, consumes the ALU's `branch_taken`, and counts retired instructions.

## Interface
Parameters:
- `RESET_PC_SRC`, 0 — value of `pc_src` during reset and idle states.

Ports:
- `clk`  in  1  — system clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `opcode`  in  7  — instruction bits [6:0], from the IR.
- `funct3`  in  3  — instruction bits [14:12].
- `funct7_5`  in  1  — instruction bit 30.
- `mem_ready`  in  1  — memory completes the current `mem_req` this cycle.
- `branch_taken`  in  1  — ALU branch result; sampled only in EXEC.
- `alu_func`  out  5  — ALU function code, registered.
- `mem_req`  out  1  — memory access request.
- `mem_we`  out  1  — write strobe; valid only with `mem_req`.
- `ir_write`  out  1  — load the IR from memory data.
- `pc_write`  out  1  — update the PC.
- `pc_src`  out  1  — 0 selects PC+4, 1 selects the branch/jump target.
- `reg_write`  out  1  — register-file write enable.
- `wb_sel`  out  2  — writeback source: 0 = ALU, 1 = memory data, 2 = old PC+4.
- `instr_done`  out  1  — one-cycle pulse on the final cycle of each instruction.
- `instret`  out  32  — retired-instruction counter.
- `trap`  out  1  — illegal instruction seen (only with `ILLEGAL_TRAP_EN`).

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, TRAP (TRAP exists only with the macro).

- **FETCH**
  - `mem_req`=1, `mem_we`=0.
  - Holds while `mem_ready`=0.
  - On the `mem_ready` cycle: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- **DECODE** — registers `alu_func` from the fields:
  - R (0110011): funct3 000 → `ALU_SUB` if `funct7_5`, else `ALU_ADD`; 100 → `ALU_XOR`; 110 → `ALU_OR`; 111 → `ALU_AND`.
  - I (0010011): 000 → `ALU_ADDI`; 100 → `ALU_XORI`; 110 → `ALU_ORI`; 111 → `ALU_ANDI`.
  - Load (0000011) → `ALU_LOAD`. Store (0100011) → `ALU_STORE`. LUI (0110111) → `ALU_LUI`. JAL (1101111) → `ALU_JUMP`.
  - Branch (1100011): 000 → `ALU_BEQ`; 001 → `ALU_BNE`; 100 → `ALU_BLT`; 101 → `ALU_BGE`.
  - Any other opcode/funct3 combination is illegal (see Configuration).
  - Legal instructions go to EXEC.
- **EXEC**
  - Branch: `pc_write`=`branch_taken`, `pc_src`=1, `instr_done`=1, then FETCH.
  - JAL: `pc_write`=1, `pc_src`=1, then WB with `wb_sel`=2.
  - Load/store: go to MEM.
  - All other instructions: go to WB with `wb_sel`=0.
- **MEM**
  - `mem_req`=1; `mem_we`=1 for stores only.
  - Holds until `mem_ready`.
  - Store: `instr_done`=1, then FETCH.
  - Load: go to WB with `wb_sel`=1.
- **WB** — `reg_write`=1, `instr_done`=1, then FETCH.
- **Counter** — `instret` increments by 1 on each `instr_done` and wraps 0xFFFFFFFF → 0.
- **Output decode**
  - All enables are a combinational decode of the state register plus the latched instruction class.
  - Each enable is 0 in every state not listed above.
  - `mem_ready` is ignored outside FETCH and MEM.

## Timing
- **Reset:** while `rst_n`=0, state = FETCH and `alu_func` = `ALU_ADD`. All other outputs (including `instret` and `trap`) are 0, except `pc_src`=`RESET_PC_SRC`.
- **Reset mid-operation:** asserting reset during a MEM wait aborts the access immediately (asynchronous). The first FETCH `mem_req` appears in the cycle after `rst_n` rises.
- **Minimum latency (zero-wait memory):**
  - ALU/LUI/JAL: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- **Memory wait states:** each cycle with `mem_ready`=0 adds exactly one cycle.
- **`alu_func` validity:** stable from the cycle after DECODE until the next DECODE.
- **`mem_ready` in the same cycle as a state entry:** completes the access in that cycle.

## Configuration
`ILLEGAL_TRAP_EN`:
- **Defined:** an illegal decode goes to TRAP.
  - `trap`=1, all enables stay 0, `instret` is frozen.
  - Exit is by reset only.
- **Undefined:** an illegal decode is treated as a NOP.
  - DECODE asserts `instr_done`=1 and returns to FETCH; `instret` increments.
  - `trap` is tied to 0.

## Test plan
- **Reset during load MEM wait:** load with `mem_ready` held 0 in MEM, assert `rst_n`=0 → `mem_req`=0 immediately, `instret`=0; after release, FETCH `mem_req`=1 on the next cycle.
- **Zero-wait ADD/SUB:** ADD then SUB (opcode 0110011, `funct7_5`=0/1), `mem_ready`=1 → `alu_func`=`ALU_ADD` then `ALU_SUB`, `reg_write` in cycle 4 of each, `instret`=2 after 8 cycles.
- **Load with wait states:** load with `mem_ready` low for 3 cycles in MEM → `wb_sel`=1, `reg_write` in cycle 8.
- **BNE taken / not taken:** BNE with `branch_taken`=1 → `pc_write`=1, `pc_src`=1 in EXEC; with `branch_taken`=0 → `pc_write`=0; both complete in 3 cycles.
- **Illegal opcode 1111111:**
  - With macro: `trap`=1, state stuck, `instret` unchanged.
  - Without macro: `instr_done` in DECODE, `instret`+1.
- **Counter wrap:** preload via 2^32−1 retirements (force) plus one store → `instret`=0, `mem_we`=1 during MEM.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing controller for the multi-cycle RISC-V datapath: FETCH/DECODE/EXEC/MEM/WB with
// ALU function decode and a retired-instruction counter. Define ILLEGAL_TRAP_EN to trap on illegal decodes.
module multicycle_ctrl_fsm #(
    parameter logic RESET_PC_SRC = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [4:0]  alu_func,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        instr_done,
    output logic [31:0] instret,
    output logic        trap
);

    localparam logic [4:0] ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_XOR  = 5'd2,  ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4,  ALU_ADDI  = 5'd5,  ALU_XORI = 5'd6,  ALU_ORI  = 5'd7;
    localparam logic [4:0] ALU_ANDI  = 5'd8,  ALU_LOAD  = 5'd9,  ALU_STORE = 5'd10, ALU_LUI = 5'd11;
    localparam logic [4:0] ALU_JUMP  = 5'd12, ALU_BEQ   = 5'd13, ALU_BNE  = 5'd14, ALU_BLT  = 5'd15;
    localparam logic [4:0] ALU_BGE   = 5'd16;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_LUI = 7'b0110111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP = 3'd5
`endif
    } state_t;

    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL} cls_t;

    state_t     r_state, w_next;
    cls_t       r_cls, w_cls;
    logic [4:0] r_alu_func, w_alu;
    logic [31:0] r_instret;
    logic       r_run;      // low from reset until the first clock edge after rst_n rises
    logic       w_legal;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_legal = 1'b1;
        w_cls   = C_ALU;
        w_alu   = r_alu_func;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000:  w_alu = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b100:  w_alu = ALU_XOR;
                    3'b110:  w_alu = ALU_OR;
                    3'b111:  w_alu = ALU_AND;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b000:  w_alu = ALU_ADDI;
                    3'b100:  w_alu = ALU_XORI;
                    3'b110:  w_alu = ALU_ORI;
                    3'b111:  w_alu = ALU_ANDI;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LOAD:  begin w_cls = C_LOAD;  w_alu = ALU_LOAD;  end
            OP_STORE: begin w_cls = C_STORE; w_alu = ALU_STORE; end
            OP_LUI:   w_alu = ALU_LUI;
            OP_JAL:   begin w_cls = C_JAL;   w_alu = ALU_JUMP;  end
            OP_BRANCH: begin
                w_cls = C_BRANCH;
                case (funct3)
                    3'b000:  w_alu = ALU_BEQ;
                    3'b001:  w_alu = ALU_BNE;
                    3'b100:  w_alu = ALU_BLT;
                    3'b101:  w_alu = ALU_BGE;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = RESET_PC_SRC;
        reg_write  = 1'b0;
        wb_sel     = 2'd0;
        instr_done = 1'b0;
        trap       = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 1'b0;
                        w_next   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_next = S_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        w_next = S_TRAP;
`else
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
`endif
                    end
                end
                S_EXEC: begin
                    case (r_cls)
                        C_BRANCH: begin
                            pc_write   = branch_taken;
                            pc_src     = 1'b1;
                            instr_done = 1'b1;
                            w_next     = S_FETCH;
                        end
                        C_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                            w_next   = S_WB;
                        end
                        C_LOAD, C_STORE: w_next = S_MEM;
                        default:         w_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (r_cls == C_STORE);
                    if (mem_ready) begin
                        instr_done = (r_cls == C_STORE);
                        w_next     = (r_cls == C_STORE) ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    wb_sel     = (r_cls == C_JAL) ? 2'd2 : (r_cls == C_LOAD) ? 2'd1 : 2'd0;
                    w_next     = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: trap = 1'b1;
`endif
                default: w_next = S_FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_cls      <= C_ALU;
            r_alu_func <= ALU_ADD;
            r_instret  <= 32'd0;
            r_run      <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (r_run && r_state == S_DECODE && w_legal) begin
                r_cls      <= w_cls;
                r_alu_func <= w_alu;
            end
            if (instr_done) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign alu_func = r_alu_func;
    assign instret  = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: builds the expected per-cycle output trace of each
// instruction from its class, memory wait counts and branch outcome, and compares it cycle by cycle.
module tb_multicycle_ctrl_fsm;

    localparam logic P_RST = 1'b0;
    localparam logic [4:0] ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_XOR  = 5'd2,  ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4,  ALU_ADDI  = 5'd5,  ALU_XORI = 5'd6,  ALU_ORI  = 5'd7;
    localparam logic [4:0] ALU_ANDI  = 5'd8,  ALU_LOAD  = 5'd9,  ALU_STORE = 5'd10, ALU_LUI = 5'd11;
    localparam logic [4:0] ALU_JUMP  = 5'd12, ALU_BEQ   = 5'd13, ALU_BNE  = 5'd14, ALU_BLT  = 5'd15;
    localparam logic [4:0] ALU_BGE   = 5'd16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5, mem_ready, branch_taken;
    logic [4:0]  alu_func;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, instr_done, trap;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
    logic [14:0] obs;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_count;
    logic [4:0]  m_alu;
    bit          m_trapped;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BR, K_JAL, K_ILL} kind_t;
    typedef struct {
        logic [14:0] exp;
        int          rdy;   // 0/1 driven, 2 = random
        int          bt;    // 0/1 driven, 2 = random
        bit          ir;    // present the instruction fields this cycle
    } cyc_t;
    cyc_t trace[$];

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.RESET_PC_SRC(P_RST)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .alu_func(alu_func),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
        .instret(instret), .trap(trap)
    );

    assign obs = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, instr_done, trap, alu_func};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] ev(input logic rq, we, irw, pcw, pcs, rw, input logic [1:0] wb,
                                       input logic dn, tr, input logic [4:0] alu);
        return {rq, we, irw, pcw, pcs, rw, wb, dn, tr, alu};
    endfunction

    task automatic add(input logic [14:0] e, input int rdy, input int bt, input bit ir);
        cyc_t c;
        c.exp = e; c.rdy = rdy; c.bt = bt; c.ir = ir;
        trace.push_back(c);
    endtask

    // Instruction table: class and ALU code for each legal opcode/funct3 combination.
    task automatic ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                              output kind_t k, output logic [4:0] code);
        k = K_ILL;
        code = m_alu;
        case (op)
            7'b0110011: begin
                k = K_ALU;
                case (f3)
                    3'd0: code = f75 ? ALU_SUB : ALU_ADD;
                    3'd4: code = ALU_XOR;
                    3'd6: code = ALU_OR;
                    3'd7: code = ALU_AND;
                    default: k = K_ILL;
                endcase
            end
            7'b0010011: begin
                k = K_ALU;
                case (f3)
                    3'd0: code = ALU_ADDI;
                    3'd4: code = ALU_XORI;
                    3'd6: code = ALU_ORI;
                    3'd7: code = ALU_ANDI;
                    default: k = K_ILL;
                endcase
            end
            7'b0000011: begin k = K_LOAD;  code = ALU_LOAD;  end
            7'b0100011: begin k = K_STORE; code = ALU_STORE; end
            7'b0110111: begin k = K_ALU;   code = ALU_LUI;   end
            7'b1101111: begin k = K_JAL;   code = ALU_JUMP;  end
            7'b1100011: begin
                k = K_BR;
                case (f3)
                    3'd0: code = ALU_BEQ;
                    3'd1: code = ALU_BNE;
                    3'd4: code = ALU_BLT;
                    3'd5: code = ALU_BGE;
                    default: k = K_ILL;
                endcase
            end
            default: k = K_ILL;
        endcase
        if (k == K_ILL) code = m_alu;
    endtask

    // Runs one instruction: wf fetch wait cycles, wm memory wait cycles; cut>=0 stops after that many cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic bt,
                             input int wf, input int wm, input int cut, input string tag);
        kind_t k;
        logic [4:0] code, old;
        logic st;
        int n;
        ref_decode(op, f3, f75, k, code);
        old = m_alu;
        trace.delete();
        for (int i = 0; i < wf; i++) add(ev(1, 0, 0, 0, P_RST, 0, 0, 0, 0, old), 0, 2, 0);
        add(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, old), 1, 2, 0);
        if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
            add(ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, old), 2, 2, 1);
            for (int i = 0; i < 4; i++) add(ev(0, 0, 0, 0, P_RST, 0, 0, 0, 1, old), 2, 2, 0);
            m_trapped = 1'b1;
`else
            add(ev(0, 0, 0, 0, P_RST, 0, 0, 1, 0, old), 2, 2, 1);
            m_count++;
`endif
        end else begin
            add(ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, old), 2, 2, 1);
            m_alu = code;
            case (k)
                K_BR: add(ev(0, 0, 0, bt, 1, 0, 0, 1, 0, code), 2, int'(bt), 0);
                K_JAL: begin
                    add(ev(0, 0, 0, 1, 1, 0, 0, 0, 0, code), 2, 2, 0);
                    add(ev(0, 0, 0, 0, P_RST, 1, 2, 1, 0, code), 2, 2, 0);
                end
                K_LOAD, K_STORE: begin
                    st = (k == K_STORE);
                    add(ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, code), 2, 2, 0);
                    for (int i = 0; i < wm; i++) add(ev(1, st, 0, 0, P_RST, 0, 0, 0, 0, code), 0, 2, 0);
                    add(ev(1, st, 0, 0, P_RST, 0, 0, st, 0, code), 1, 2, 0);
                    if (!st) add(ev(0, 0, 0, 0, P_RST, 1, 1, 1, 0, code), 2, 2, 0);
                end
                default: begin
                    add(ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, code), 2, 2, 0);
                    add(ev(0, 0, 0, 0, P_RST, 1, 0, 1, 0, code), 2, 2, 0);
                end
            endcase
            m_count++;
        end
        n = (cut < 0) ? trace.size() : cut;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready    = (trace[i].rdy == 2) ? 1'($urandom) : 1'(trace[i].rdy);
            branch_taken = (trace[i].bt == 2) ? 1'($urandom) : 1'(trace[i].bt);
            if (trace[i].ir) begin
                opcode = op; funct3 = f3; funct7_5 = f75;
            end else begin
                opcode = 7'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
            end
            #1 check($sformatf("%s cyc%0d", tag, i), obs, trace[i].exp);
        end
        if (cut < 0) begin
            @(posedge clk);
            #1 check($sformatf("%s instret", tag), instret, m_count);
        end
    endtask

    // Asserts reset at the current time, holds it over a clock edge with mem_ready high, then releases.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        m_count = 32'd0; m_alu = ALU_ADD; m_trapped = 1'b0;
        #1 check({tag, " assert"}, obs, ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, ALU_ADD));
        check({tag, " instret"}, instret, 32'd0);
        @(negedge clk);
        mem_ready = 1'b1; branch_taken = 1'($urandom); opcode = 7'b0110011; funct3 = 3'd1;
        #1 check({tag, " hold"}, obs, ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, ALU_ADD));
        rst_n = 1'b1;
        #1 check({tag, " release"}, obs, ev(0, 0, 0, 0, P_RST, 0, 0, 0, 0, ALU_ADD));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pool [9];
        logic [6:0] op;
        pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                 7'b1101111, 7'b1100011, 7'b1111111, 7'b0001111};
        rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        m_count = 32'd0; m_alu = ALU_ADD; m_trapped = 1'b0;
        @(negedge clk);
        do_reset("reset");

        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, -1, "add");
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0, -1, "sub");
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3, -1, "load_wait3");
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0, -1, "bne_taken");
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0, -1, "bne_not_taken");
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, -1, "illegal");
        if (m_trapped) do_reset("trap_exit");
        run_instr(7'b1101111, 3'd5, 1'b0, 1'b0, 2, 0, -1, "jal");
        run_instr(7'b0110111, 3'd3, 1'b1, 1'b0, 0, 0, -1, "lui");
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1, 2, -1, "store_wait");
        run_instr(7'b0110011, 3'd1, 1'b0, 1'b0, 0, 0, -1, "r_illegal_f3");

        for (int n = 0; n < 60; n++) begin
            op = pool[$urandom_range(8, 0)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), -1, $sformatf("rnd%0d", n));
            if (m_trapped) do_reset("rnd_trap_exit");
        end

        // Load stalled in MEM (F, D, E, then three wait cycles), aborted by reset mid-cycle.
        run_instr(7'b0000011, 3'd0, 1'b0, 1'b0, 0, 6, 6, "load_abort");
        #1 do_reset("abort_reset");
        run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0, -1, "after_abort");

        // Counter wrap: preload the counter to all ones, then retire one store.
        @(negedge clk);
        force dut.r_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        m_count = 32'hFFFF_FFFF;
        run_instr(7'b0100011, 3'd0, 1'b0, 1'b0, 0, 0, -1, "store_wrap");
        check("wrap instret zero", instret, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
